// File: rtl/rr_arb_if.sv
// Request/grant bundle for rr_arb: requester side drives en/req, arbiter returns
// registered grant plus a combinational any-request flag and debug visibility of its state.
interface rr_arb_if #(
  parameter int NUM_REQ = 8
);
  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a requester holds req[i] high for as long as it wants service;
  // gnt[i] high means it owns the resource this cycle, and dropping req[i]
  // releases it at the next edge (no separate ready/ack).
  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_valid;
  logic               req_up;
  logic               dbg_busy;
  logic [IW-1:0]      dbg_ptr;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, req_up, dbg_busy, dbg_ptr
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, req_up, dbg_busy, dbg_ptr
  );
endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter with grant lock and a rotating priority pointer.
// Optional macro RR_ARB_MAX_HOLD_EN limits a holder to MAX_HOLD cycles while others wait.
module rr_arb #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  rr_arb_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      cand;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      win_ptr;
  logic               win_found;
  logic               force_off;

  if (NUM_REQ < 2 || NUM_REQ > 64) begin : g_bad_num_req
    $error("rr_arb: NUM_REQ must be in 2..64");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("rr_arb: MAX_HOLD must be >= 1");
  end

`ifdef RR_ARB_MAX_HOLD_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Only yield when somebody else is actually waiting.
  assign force_off = (state_q == BUSY) && (cnt_q >= CW'(MAX_HOLD)) &&
                     (|(bus.req & ~gnt_q));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign force_off = 1'b0;
`endif

  // First set request at or after ptr, wrapping at NUM_REQ (works for non power-of-2).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k >= NUM_REQ) ? IW'(int'(ptr_q) + k - NUM_REQ)
                                          : IW'(int'(ptr_q) + k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_ptr = (win_idx == IW'(NUM_REQ - 1)) ? '0 : IW'(win_idx + 1'b1);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
`ifdef RR_ARB_MAX_HOLD_EN
    cnt_d   = cnt_q;
`endif
    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = '0;
      gnt_d   = '0;
`ifdef RR_ARB_MAX_HOLD_EN
      cnt_d   = '0;
`endif
    end else if (state_q == IDLE || !bus.req[idx_q] || force_off) begin
      if (win_found) begin
        state_d        = BUSY;
        ptr_d          = win_ptr;
        idx_d          = win_idx;
        gnt_d          = '0;
        gnt_d[win_idx] = 1'b1;
`ifdef RR_ARB_MAX_HOLD_EN
        cnt_d          = CW'(1);
`endif
      end else begin
        state_d = IDLE;
        idx_d   = '0;
        gnt_d   = '0;
`ifdef RR_ARB_MAX_HOLD_EN
        cnt_d   = '0;
`endif
      end
    end else begin
`ifdef RR_ARB_MAX_HOLD_EN
      cnt_d = (cnt_q >= CW'(MAX_HOLD)) ? CW'(1) : CW'(cnt_q + 1'b1);
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == BUSY);
  assign bus.req_up    = |bus.req;
  assign bus.dbg_busy  = (state_q == BUSY);
  assign bus.dbg_ptr   = ptr_q;
endmodule

// File: tb/tb_rr_arb.sv
// Bench for rr_arb: 4- and 5-requester instances, directed vector tables,
// hand-written reset/hold sequences, and randomized traffic against a reference model.
module tb_rr_arb;
  localparam int N4 = 4;
  localparam int N5 = 5;
  localparam int MH = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  rr_arb_if #(.NUM_REQ(N4)) b4 ();
  rr_arb_if #(.NUM_REQ(N5)) b5 ();

  rr_arb #(.NUM_REQ(N4), .MAX_HOLD(MH)) dut4 (.clock(clock), .reset_n(reset_n), .bus(b4));
  rr_arb #(.NUM_REQ(N5), .MAX_HOLD(MH)) dut5 (.clock(clock), .reset_n(reset_n), .bus(b5));

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: holder index (-1 = nobody), next-search start, hold cycles.
  int h4 = -1, p4 = 0, c4 = 0;
  int h5 = -1, p5 = 0, c5 = 0;
  int nh4, np4, nc4, nh5, np5, nc5;

  task automatic ref_next(input int n, input logic en, input logic [63:0] req,
                          input int h, input int p, input int c,
                          output int nh, output int np, output int nc);
    bit keep;
    nh = h; np = p; nc = c;
    if (!en) begin
      nh = -1;
      nc = 0;
    end else begin
      keep = (h >= 0) ? bit'(req[h]) : 1'b0;
`ifdef RR_ARB_MAX_HOLD_EN
      if (keep && c >= MH) begin
        for (int j = 0; j < n; j++)
          if (j != h && req[j]) keep = 1'b0;
      end
`endif
      if (keep) begin
        nc = (c >= MH) ? 1 : c + 1;
      end else begin
        nh = -1;
        nc = 0;
        for (int k = 0; k < n; k++) begin
          int j;
          j = (p + k) % n;
          if (nh < 0 && req[j]) begin
            nh = j;
            np = (j + 1) % n;
            nc = 1;
          end
        end
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h4 <= -1; p4 <= 0; c4 <= 0;
      h5 <= -1; p5 <= 0; c5 <= 0;
    end else begin
      ref_next(N4, b4.en, 64'(b4.req), h4, p4, c4, nh4, np4, nc4);
      ref_next(N5, b5.en, 64'(b5.req), h5, p5, c5, nh5, np5, nc5);
      h4 <= nh4; p4 <= np4; c4 <= nc4;
      h5 <= nh5; p5 <= np5; c5 <= nc5;
    end
  end

  function automatic logic [63:0] hot(input int h);
    return (h < 0) ? 64'd0 : (64'd1 << h);
  endfunction

  function automatic int idx_of(input logic [63:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic check_model();
    check("m4_gnt",   64'(b4.gnt),       hot(h4));
    check("m4_idx",   64'(b4.gnt_idx),   64'((h4 < 0) ? 0 : h4));
    check("m4_valid", 64'(b4.gnt_valid), 64'(h4 >= 0));
    check("m4_ptr",   64'(b4.dbg_ptr),   64'(p4));
    check("m4_rqup",  64'(b4.req_up),    64'(|b4.req));
    check("m5_gnt",   64'(b5.gnt),       hot(h5));
    check("m5_idx",   64'(b5.gnt_idx),   64'((h5 < 0) ? 0 : h5));
    check("m5_valid", 64'(b5.dbg_busy),  64'(h5 >= 0));
    check("m5_ptr",   64'(b5.dbg_ptr),   64'(p5));
    check("m5_rqup",  64'(b5.req_up),    64'(|b5.req));
  endtask

  task automatic drive(input logic e4, input logic [3:0] r4, input logic e5, input logic [4:0] r5);
    @(negedge clock);
    b4.en = e4; b4.req = r4;
    b5.en = e5; b5.req = r5;
    @(posedge clock);
    #1;
  endtask

  task automatic check4(input string name, input logic [3:0] g);
    check({name, "_gnt"},   64'(b4.gnt),       64'(g));
    check({name, "_idx"},   64'(b4.gnt_idx),   64'(idx_of(64'(g))));
    check({name, "_valid"}, 64'(b4.gnt_valid), 64'(|g));
  endtask

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t       tbl[12];
  logic [4:0] s5_req[6];
  logic [4:0] s5_gnt[6];
  logic [3:0] hold_exp[5];
  logic [3:0] r4q;
  logic [4:0] r5q;

  initial begin
    tbl[0]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[2]  = '{1'b1, 4'b1110, 4'b0010};
    tbl[3]  = '{1'b1, 4'b1101, 4'b0100};
    tbl[4]  = '{1'b1, 4'b1011, 4'b1000};
    tbl[5]  = '{1'b1, 4'b0111, 4'b0001};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b1, 4'b0100, 4'b0100};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[9]  = '{1'b1, 4'b1111, 4'b1000};
    tbl[10] = '{1'b1, 4'b0110, 4'b0010};
    tbl[11] = '{1'b1, 4'b0110, 4'b0010};

    s5_req = '{5'b10001, 5'b10000, 5'b10001, 5'b00001, 5'b10001, 5'b10000};
    s5_gnt = '{5'b00001, 5'b10000, 5'b10000, 5'b00001, 5'b00001, 5'b10000};

`ifdef RR_ARB_MAX_HOLD_EN
    hold_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001};
`else
    hold_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

    b4.en = 1'b0; b4.req = '0;
    b5.en = 1'b0; b5.req = '0;

    // Reset state, and req_up following req while reset is held.
    repeat (2) @(posedge clock);
    #1;
    check4("rst", 4'b0000);
    check("rst_ptr", 64'(b4.dbg_ptr), 64'd0);
    @(negedge clock);
    b4.req = 4'b0101;
    #1;
    check("rst_rqup_hi", 64'(b4.req_up), 64'd1);
    b4.req = 4'b0000;
    #1;
    check("rst_rqup_lo", 64'(b4.req_up), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed rotation, wrap, idle, en-revoke and pointer retention.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].en, tbl[i].req, 1'b0, 5'b0);
      check4($sformatf("tbl%0d", i), tbl[i].gnt);
      check($sformatf("tbl%0d_rqup", i), 64'(b4.req_up), 64'(|tbl[i].req));
    end

    // Asynchronous reset mid-grant, then first arbitration restarts from 0.
    drive(1'b1, 4'b0100, 1'b0, 5'b0);
    check4("pre_rst", 4'b0100);
    @(negedge clock);
    b4.req = 4'b1100;
    #2;
    reset_n = 1'b0;
    #1;
    check4("async_rst", 4'b0000);
    check("async_rst_rqup", 64'(b4.req_up), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check4("post_rst", 4'b0100);

    // Constant two-requester traffic, then a lone requester that keeps the grant.
    drive(1'b1, 4'b0000, 1'b0, 5'b0);
    check4("to_idle", 4'b0000);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0011, 1'b0, 5'b0);
      check4($sformatf("hold2_%0d", i), hold_exp[i]);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'b0001, 1'b0, 5'b0);
      check4($sformatf("hold1_%0d", i), 4'b0001);
    end

    // Five requesters: endpoints 0 and 4 alternate across the non-power-of-2 wrap.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b0, 1'b1, s5_req[i]);
      check($sformatf("n5_%0d_gnt", i), 64'(b5.gnt), 64'(s5_gnt[i]));
      check($sformatf("n5_%0d_idx", i), 64'(b5.gnt_idx), 64'(idx_of(64'(s5_gnt[i]))));
      check($sformatf("n5_%0d_rqup", i), 64'(b5.req_up), 64'(|s5_req[i]));
    end

    // Randomized traffic on both instances against the reference model.
    r4q = '0;
    r5q = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r4q = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r5q = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 9) != 0, r4q, $urandom_range(0, 9) != 0, r5q);
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb.md
RR_ARB -- requirements
Module: rr_arb

Interface
REQ-001 Parameter NUM_REQ, default 8: number of requesters, legal range 2..64, non-power-of-2 allowed.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per requester, legal range >=1, used only with RR_ARB_MAX_HOLD_EN.
REQ-003 Port list SHALL be as follows; one clock, reset asynchronous active-low.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  arbitration enable; low blocks and revokes grants.
REQ-007 req  input  NUM_REQ  request vector, bit i = requester i.
REQ-008 gnt  output  NUM_REQ  registered one-hot grant, all-zero when idle.
REQ-009 gnt_idx  output  $clog2(NUM_REQ)  registered index of granted requester, 0 when idle.
REQ-010 gnt_valid  output  1  registered, high when gnt is non-zero.
REQ-011 req_up  output  1  combinational OR of req, independent of en and state.

Function
REQ-012 Two states: IDLE (gnt=0) and BUSY (exactly one gnt bit high); gnt, gnt_idx and gnt_valid SHALL change only on the rising clock edge.
REQ-013 Priority pointer ptr (range 0..NUM_REQ-1): winner = first set req bit searching ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1 (ascending with wrap).
REQ-014 Latency: req sampled in cycle t with en=1 in IDLE -> gnt asserted in cycle t+1.
REQ-015 IDLE: en=1 and |req=1 -> grant winner, go BUSY, ptr <= (winner+1) mod NUM_REQ; otherwise stay IDLE, ptr unchanged.
REQ-016 BUSY with en=1 and req[gnt_idx]=1: grant held (lock), ptr unchanged.
REQ-017 BUSY with en=1 and req[gnt_idx]=0: same edge re-arbitrates from current ptr; winner found -> back-to-back grant, ptr <= (winner+1) mod NUM_REQ; none -> IDLE.
REQ-018 Any state with en=0: next edge gnt=0, gnt_valid=0, gnt_idx=0, state IDLE, ptr unchanged.
REQ-019 Pointer wrap: grant to NUM_REQ-1 SHALL set ptr to 0; no index >= NUM_REQ SHALL ever be granted or stored.
REQ-020 Simultaneous release of the holder and new requests: the released requester has lowest priority because ptr already points past it.
REQ-021 At most one gnt bit SHALL be high in any cycle; gnt_valid == |gnt and gnt[gnt_idx] == gnt_valid always.

Reset
REQ-022 reset_n low SHALL immediately clear gnt, gnt_idx and gnt_valid to 0, ptr to 0, state to IDLE, and hold counter to 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant asynchronously; first arbitration after reset_n deasserts follows REQ-015 with ptr=0.
REQ-024 req_up SHALL remain a function of req only, during reset included.

Configuration
REQ-025 Macro RR_ARB_MAX_HOLD_EN defined: hold counter counts BUSY cycles of the current holder and resets on every new grant.
REQ-026 With RR_ARB_MAX_HOLD_EN, a holder reaching MAX_HOLD grant cycles while any other req bit is set SHALL be forced off and re-arbitrated at that edge per REQ-017, even with its req high.
REQ-027 With RR_ARB_MAX_HOLD_EN and no other request pending at the limit: holder keeps grant, counter restarts at 1, ptr unchanged.
REQ-028 Macro undefined: no hold counter exists, grant lock is unlimited, MAX_HOLD is ignored.

Verification (NUM_REQ=4, MAX_HOLD=2 unless noted)
REQ-029 After reset, en=1, req=4'b1111 for one cycle then held -> gnt=4'b0001, gnt_idx=0 next cycle; ptr=1.
REQ-030 Holder 0 drops req, req=4'b1110 -> next edge gnt=4'b0010; repeated single-cycle drops rotate 1->2->3->0 (wrap check).
REQ-031 BUSY on idx 2, en driven 0 for one cycle -> gnt=0, gnt_valid=0 next edge; en=1 with req=4'b1111 -> gnt=4'b1000 (ptr=3 kept).
REQ-032 reset_n pulsed low while gnt=4'b0100 -> gnt=0 without clock edge; after release req=4'b1100 -> gnt=4'b0100 (ptr=0 search).
REQ-033 With RR_ARB_MAX_HOLD_EN, req=4'b0011 held constant -> gnt 0001,0001,0010,0010,0001 ...; req=4'b0001 alone -> gnt=0001 held indefinitely.
REQ-034 NUM_REQ=5, req=5'b10001 held and toggled off/on by holder -> grants alternate 4 and 0, gnt_idx never >4, req_up tracks |req combinationally.
